// File: rtl/pc_seq_pkg.sv
// Shared opcode/state encodings and instruction field positions for the PC sequencer.
package pc_seq_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_JMP  = 4'd1,
        OP_CALL = 4'd2,
        OP_RET  = 4'd3,
        OP_JC   = 4'd4,
        OP_BACK = 4'd5,
        OP_HALT = 4'd6
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; dout shows the top entry combinationally, push/pop take effect on the edge.
// Synchronous clear wins over push/pop; push when full and pop when empty are ignored.
module ret_stack #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  top_idx;
    logic              do_push;

    assign full    = (sp_q == PTR_W'(DEPTH));
    assign empty   = (sp_q == '0);
    assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign dout    = mem_q[top_idx];
    assign do_push = push && !full && !clr;

    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (push && !full) begin
            sp_d = sp_q + PTR_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        sp_q <= sp_d;
        if (do_push) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Decodes ROM words and steers the up/down program counter: one counter action per instruction.
// Two cycles per instruction (FETCH covers ROM latency, EXEC drives strobes combinationally).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk5m,
    input  logic               rst,
    input  logic               run,
    input  logic               cond,
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    output logic               cnt_en,
    output logic               cnt_load,
    output logic               cnt_updn,
    output logic [ADDR_W-1:0]  cnt_data,
    output logic               halted,
    output logic               stack_err
);

    state_t              state_q, state_d;
    logic                stack_err_q, stack_err_d;
    logic [3:0]          opc;
    logic [ADDR_W-1:0]   target;
    logic                stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]   stk_dout;
    logic [ADDR_W-1:0]   ret_addr;

    assign opc      = instr[OPC_MSB:OPC_LSB];
    assign target   = instr[ADDR_W-1:0];
    assign ret_addr = pc + ADDR_W'(1);

    generate
        if (OPC_LSB > ADDR_W) begin : g_gap
            logic unused_gap_bits;
            assign unused_gap_bits = ^instr[OPC_LSB-1:ADDR_W];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        stack_err_d = stack_err_q;
        cnt_en      = 1'b0;
        cnt_load    = 1'b0;
        cnt_updn    = 1'b0;
        cnt_data    = '0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                // run is only consulted here, at the instruction boundary
                state_d = run ? ST_FETCH : ST_IDLE;
                case (opc)
                    OP_JMP: begin
                        cnt_load = 1'b1;
                        cnt_data = target;
                    end
                    OP_CALL: begin
                        if (stk_full) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else begin
                            stk_push = 1'b1;
                            cnt_load = 1'b1;
                            cnt_data = target;
                        end
                    end
                    OP_RET: begin
                        if (stk_empty) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else begin
                            stk_pop  = 1'b1;
                            cnt_load = 1'b1;
                            cnt_data = stk_dout;
                        end
                    end
                    OP_JC: begin
                        if (cond) begin
                            cnt_load = 1'b1;
                            cnt_data = target;
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                    OP_BACK: begin
                        cnt_en   = 1'b1;
                        cnt_updn = 1'b1;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: cnt_en = 1'b1;
                endcase
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk5m) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stack_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stack_err_q <= stack_err_d;
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign stack_err = stack_err_q;

    ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ret_stack (
        .clk   (clk5m),
        .clr   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (ret_addr),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule
